// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encodings and per-entry state.
// Pure declarations; no timing.
// No flow control.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bpCtr_t;

    localparam bpCtr_t INIT_CTR  = WNT;
    localparam bpCtr_t ALLOC_CTR = WT;

    // Tag and target widths follow the instantiating module's XLEN/ENTRIES,
    // so those fields are stored in parallel arrays next to this struct.
    typedef struct packed {
        logic   valid;
        bpCtr_t ctr;
    } bpEntry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state (increments on taken, decrements otherwise).
// Combinational, zero cycles.
// No flow control.
import bp_pkg::*;

module bp_sat_ctr (
    input  bpCtr_t ctr,
    input  logic   taken,
    output bpCtr_t nextCtr
);

    always_comb begin
        nextCtr = ctr;
        if (taken) begin
            if (ctr != ST) nextCtr = bpCtr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) nextCtr = bpCtr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit predictor; optional BP_STATS_EN adds branch/mispredict counters.
// Lookup and mispredict are combinational (0 cycles); table updates land on the next clk edge.
// No backpressure: one lookup and one update accepted every cycle.
import bp_pkg::*;

module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    input  logic            upd_valid_e,
    input  logic [XLEN-1:0] upd_pc_e,
    input  logic            upd_taken_e,
    input  logic [XLEN-1:0] upd_target_e,
    input  logic            pred_taken_e,
    input  logic [XLEN-1:0] pred_target_e,
    output logic            mispredict_e,
    output logic [XLEN-1:0] redirect_pc_e
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    bpEntry_t        entries [ENTRIES];
    logic [TAGW-1:0] tags    [ENTRIES];
    logic [XLEN-1:0] targets [ENTRIES];

    logic [IDXW-1:0] fIdx, eIdx;
    logic [TAGW-1:0] fTag, eTag;
    logic            fHit, eHit;
    bpCtr_t          ctrNext;

    assign fIdx = pc_f[IDXW+1:2];
    assign fTag = pc_f[XLEN-1:IDXW+2];
    assign eIdx = upd_pc_e[IDXW+1:2];
    assign eTag = upd_pc_e[XLEN-1:IDXW+2];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign fHit          = entries[fIdx].valid && (tags[fIdx] == fTag);
    assign pred_taken_f  = fHit && entries[fIdx].ctr[1];
    assign pred_target_f = pred_taken_f ? targets[fIdx] : pc_f + XLEN'(4);

    assign eHit = entries[eIdx].valid && (tags[eIdx] == eTag);

    bp_sat_ctr u_satCtr (
        .ctr     (entries[eIdx].ctr),
        .taken   (upd_taken_e),
        .nextCtr (ctrNext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '{valid: 1'b0, ctr: INIT_CTR};
            end
        end else if (upd_valid_e) begin
            if (eHit) begin
                entries[eIdx].ctr <= ctrNext;
            end else if (upd_taken_e) begin
                entries[eIdx] <= '{valid: 1'b1, ctr: ALLOC_CTR};
            end
        end
    end

    // Taken updates either hit (tag unchanged) or allocate, so the tag write is unconditional.
    always_ff @(posedge clk) begin
        if (rst && upd_valid_e && upd_taken_e) begin
            tags[eIdx]    <= eTag;
            targets[eIdx] <= upd_target_e;
        end
    end

    assign mispredict_e  = upd_valid_e &&
                           ((pred_taken_e != upd_taken_e) ||
                            (upd_taken_e && (pred_target_e != upd_target_e)));
    assign redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + XLEN'(4);

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_valid_e)  stat_branches <= stat_branches + 32'd1;
            if (mispredict_e) stat_mispred  <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus queues expectations, a negedge monitor compares.
// Also covers the BP_STATS_EN build when that macro is defined.
`timescale 1ns/1ps

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        upd_valid_e;
    logic [31:0] upd_pc_e;
    logic        upd_taken_e;
    logic [31:0] upd_target_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_f          (pc_f),
        .pred_taken_f  (pred_taken_f),
        .pred_target_f (pred_target_f),
        .upd_valid_e   (upd_valid_e),
        .upd_pc_e      (upd_pc_e),
        .upd_taken_e   (upd_taken_e),
        .upd_target_e  (upd_target_e),
        .pred_taken_e  (pred_taken_e),
        .pred_target_e (pred_target_e),
        .mispredict_e  (mispredict_e),
        .redirect_pc_e (redirect_pc_e)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    // kind: 0 pred_taken_f, 1 pred_target_f, 2 mispredict_e, 3 redirect_pc_e,
    //       4 stat_branches, 5 stat_mispred
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   nBr    = 0;
    int   nMis   = 0;

    task automatic push(input string nm, input int kind, input logic [31:0] val);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.val  = val;
        expQ.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        upd_valid_e = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                        input string nm);
        pc_f = pc;
        push({nm, "_taken"}, 0, {31'd0, tk});
        push({nm, "_target"}, 1, tg);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic pTk, input logic [31:0] pTg,
                       input logic expMis, input logic [31:0] expRed, input string nm);
        upd_valid_e   = 1'b1;
        upd_pc_e      = pc;
        upd_taken_e   = tk;
        upd_target_e  = tg;
        pred_taken_e  = pTk;
        pred_target_e = pTg;
        push({nm, "_mispredict"}, 2, {31'd0, expMis});
        push({nm, "_redirect"}, 3, expRed);
        nBr++;
        if (expMis) nMis++;
    endtask

    task automatic chkStats(input string nm);
`ifdef BP_STATS_EN
        push({nm, "_stat_branches"}, 4, nBr);
        push({nm, "_stat_mispred"}, 5, nMis);
`else
        if (nm.len() < 0) push(nm, 4, 0);
`endif
    endtask

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                case (e.kind)
                    0:       act = {31'd0, pred_taken_f};
                    1:       act = pred_target_f;
                    2:       act = {31'd0, mispredict_e};
                    3:       act = redirect_pc_e;
`ifdef BP_STATS_EN
                    4:       act = stat_branches;
                    5:       act = stat_mispred;
`endif
                    default: act = 32'hDEAD_BEEF;
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        rst           = 1'b0;
        pc_f          = 32'h100;
        upd_valid_e   = 1'b0;
        upd_pc_e      = '0;
        upd_taken_e   = 1'b0;
        upd_target_e  = '0;
        pred_taken_e  = 1'b0;
        pred_target_e = '0;

        cyc();
        look(32'h100, 1'b0, 32'h104, "in_reset");
        push("in_reset_nomisp", 2, 0);
        chkStats("in_reset");
        cyc();
        rst = 1'b1;
        look(32'h100, 1'b0, 32'h104, "post_reset");

        // Allocate 0x100; same-cycle lookup must still see the empty entry.
        cyc();
        look(32'h100, 1'b0, 32'h104, "alloc_pre");
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200, "alloc");
        cyc();
        look(32'h100, 1'b1, 32'h200, "alloc_hit");

        // Two not-taken: WT -> WNT -> SNT.
        cyc();
        look(32'h100, 1'b1, 32'h200, "nt1_pre");
        upd(32'h100, 1'b0, 32'h600, 1'b1, 32'h200, 1'b1, 32'h104, "nt1");
        cyc();
        look(32'h100, 1'b0, 32'h104, "nt1_post");
        upd(32'h100, 1'b0, 32'h600, 1'b0, 32'h104, 1'b0, 32'h104, "nt2");

        // Four taken from SNT saturate at ST; last one rewrites the target.
        cyc();
        look(32'h100, 1'b0, 32'h104, "nt2_post");
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200, "t1");
        cyc();
        look(32'h100, 1'b0, 32'h104, "t1_post");
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200, "t2");
        cyc();
        look(32'h100, 1'b1, 32'h200, "t2_post");
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200, "t3");
        cyc();
        look(32'h100, 1'b1, 32'h200, "t4_pre");
        upd(32'h100, 1'b1, 32'h280, 1'b1, 32'h200, 1'b1, 32'h280, "t4_tgt");
        cyc();
        look(32'h100, 1'b1, 32'h280, "t4_post");
        upd(32'h100, 1'b0, 32'h600, 1'b1, 32'h280, 1'b1, 32'h104, "sat_nt1");
        cyc();
        look(32'h100, 1'b1, 32'h280, "sat_wt");
        upd(32'h100, 1'b0, 32'h600, 1'b1, 32'h280, 1'b1, 32'h104, "sat_nt2");
        cyc();
        look(32'h100, 1'b0, 32'h104, "sat_wnt");

        // Same index, different tag evicts the occupant.
        upd(32'h140, 1'b1, 32'h500, 1'b0, 32'h144, 1'b1, 32'h500, "alias_alloc");
        cyc();
        look(32'h100, 1'b0, 32'h104, "alias_evict");
        cyc();
        look(32'h140, 1'b1, 32'h500, "alias_hit");
        upd(32'h180, 1'b0, 32'h700, 1'b0, 32'h184, 1'b0, 32'h184, "nt_miss");
        cyc();
        look(32'h140, 1'b1, 32'h500, "nt_miss_keep");
        cyc();
        look(32'h180, 1'b0, 32'h184, "nt_miss_noalloc");

        upd(32'h300, 1'b1, 32'h400, 1'b0, 32'h304, 1'b1, 32'h400, "misp_a");
        cyc();
        look(32'h300, 1'b1, 32'h400, "misp_a_alloc");
        upd(32'h300, 1'b0, 32'h400, 1'b1, 32'h400, 1'b1, 32'h304, "misp_b");
        cyc();
        look(32'h300, 1'b0, 32'h304, "misp_b_post");
        pred_taken_e = 1'b1;
        upd_taken_e  = 1'b0;
        push("novalid_misp", 2, 0);

        cyc();
        look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "wrap");
        upd(32'h104, 1'b1, 32'h10, 1'b0, 32'h108, 1'b1, 32'h10, "idx1_alloc");
        cyc();
        look(32'h107, 1'b1, 32'h10, "idx1_lowbits");
        cyc();
        look(32'h100, 1'b0, 32'h104, "idx0_indep");
        chkStats("pre_reset");

        // Mid-run reset with a coincident update that must be discarded.
        cyc();
        rst = 1'b0;
        upd(32'h104, 1'b1, 32'h20, 1'b0, 32'h108, 1'b1, 32'h20, "rst_upd");
        look(32'h104, 1'b0, 32'h108, "rst_mid");
        nBr  = 0;
        nMis = 0;
        cyc();
        rst = 1'b1;
        look(32'h104, 1'b0, 32'h108, "rst_after");
        chkStats("rst_after");
        cyc();
        look(32'h300, 1'b0, 32'h304, "rst_after_300");

        repeat (2) cyc();
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, >= 2).
REQ-002 SHALL have parameter XLEN, default 32, PC/target width.
REQ-003 SHALL have ports, in this order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- pc_f  input  XLEN  fetch-stage PC being looked up.
- pred_taken_f  output  1  predicted taken for pc_f.
- pred_target_f  output  XLEN  predicted next PC for pc_f.
- upd_valid_e  input  1  execute stage resolved a branch/jump this cycle.
- upd_pc_e  input  XLEN  PC of resolved instruction.
- upd_taken_e  input  1  actual outcome.
- upd_target_e  input  XLEN  actual taken target.
- pred_taken_e  input  1  prediction carried down the pipe with the instruction.
- pred_target_e  input  XLEN  predicted target carried down the pipe.
- mispredict_e  output  1  flush request to fetch/decode.
- redirect_pc_e  output  XLEN  corrected PC on mispredict.

Function
REQ-004 SHALL hold per entry: valid (1b), tag, target (XLEN), 2-bit saturating counter.
REQ-005 SHALL index with pc[log2(ENTRIES)+1:2] and tag with pc[XLEN-1:log2(ENTRIES)+2]; pc[1:0] ignored.
REQ-006 SHALL perform lookup combinationally, with zero-cycle latency: hit = valid && tag match.
REQ-007 SHALL drive pred_taken_f = hit && ctr[1].
REQ-008 SHALL drive pred_target_f = stored target when pred_taken_f, else pc_f+4, wrapping modulo 2^XLEN.
REQ-009 SHALL apply updates on the rising clk edge when upd_valid_e=1.
- Hit: counter increments (taken) or decrements (not taken), saturating at 3 and 0.
- Target is rewritten only when taken.
REQ-010 SHALL, on update miss with upd_taken_e=1, allocate the entry (overwriting any occupant): valid=1, new tag, target=upd_target_e, ctr=2'b10.
REQ-011 SHALL NOT allocate on update miss with upd_taken_e=0; the entry is unchanged.
REQ-012 SHALL, when lookup and update hit the same index in one cycle, return pre-update state to the lookup (no bypass).
REQ-013 SHALL drive mispredict_e = upd_valid_e && ((pred_taken_e != upd_taken_e) || (upd_taken_e && pred_target_e != upd_target_e)), combinationally.
REQ-014 SHALL drive redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e+4.
REQ-015 SHALL hold mispredict_e=0 whenever upd_valid_e=0; redirect_pc_e is don't-care then.
REQ-016 SHALL perform updates regardless of mispredict_e.

Reset
REQ-017 SHALL, while rst=0, clear every valid bit and set every counter to 2'b01 asynchronously; targets and tags are not reset.
REQ-018 SHALL, during and after reset until the first allocation, output pred_taken_f=0 and pred_target_f=pc_f+4.
REQ-019 SHALL discard an update coinciding with rst=0; table state after deassertion equals the reset state.

Configuration
REQ-020 SHALL, with BP_STATS_EN defined, add outputs stat_branches (32b) and stat_mispred (32b).
- stat_branches increments on each upd_valid_e.
- stat_mispred increments on each mispredict_e.
- Both reset to 0 and wrap from 2^32-1 to 0.
REQ-021 SHALL, without BP_STATS_EN, omit these ports and counters; all other behaviour is identical.

Structure
REQ-022 SHALL take from shared package bp_pkg:
- counter encodings SNT=00, WNT=01, WT=10, ST=11;
- predictor entry struct type;
- INIT_CTR=WNT, ALLOC_CTR=WT.
REQ-023 SHALL implement saturating-counter next-state in sub-module bp_sat_ctr (inputs ctr, taken; output next ctr).

Verification
REQ-024 Reset then pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104.
REQ-025 Update pc=0x100, taken, target 0x200 -> next cycle pc_f=0x100 gives pred_taken_f=1, pred_target_f=0x200; two not-taken updates -> pred_taken_f=0.
REQ-026 Four taken updates on 0x100, then one not-taken -> ctr=WT, still predicts taken (saturation verified).
REQ-027 ENTRIES=16: allocate 0x100, then allocate 0x140 (same index, different tag) -> pc_f=0x100 gives pred_taken_f=0.
REQ-028 upd_valid_e=1, pc 0x300, pred_taken_e=0, upd_taken_e=1, target 0x400 -> mispredict_e=1, redirect_pc_e=0x400; not-taken/pred-taken case -> redirect_pc_e=0x304.
REQ-029 Assert rst=0 mid-run with upd_valid_e=1 -> all entries invalid; BP_STATS_EN build shows both stat counters 0.
